// File: rtl/rice_core_ex_forwarding_unit.sv
// Execute-stage operand forwarding over a DEPTH-entry result history.
// Supports pending results (loads in flight) with late resolution.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_enable                0 clears all history on the next edge
//   i_stall                 1 holds history (resolution still applies)
//   i_result_*              result pushed into h[0] each unstalled edge
//   i_resolve_*             value for the single pending entry
//   i_rs, i_rs_value        packed per-port source index / regfile value
//   o_rs_value              packed forwarded operand values
//   o_forwarded, o_hazard   per-port bypass taken / pending dependency
module rice_core_ex_forwarding_unit #(
  parameter int XLEN       = 32,
  parameter int RS_WIDTH   = 5,
  parameter int DEPTH      = 2,
  parameter int READ_PORTS = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic                         i_stall,
  input  logic                         i_result_valid,
  input  logic [RS_WIDTH-1:0]          i_result_rd,
  input  logic [XLEN-1:0]              i_result_value,
  input  logic                         i_result_pending,
  input  logic                         i_resolve_valid,
  input  logic [XLEN-1:0]              i_resolve_value,
  input  logic [READ_PORTS*RS_WIDTH-1:0] i_rs,
  input  logic [READ_PORTS*XLEN-1:0]   i_rs_value,
  output logic [READ_PORTS*XLEN-1:0]   o_rs_value,
  output logic [READ_PORTS-1:0]        o_forwarded,
  output logic [READ_PORTS-1:0]        o_hazard
);

  logic [DEPTH-1:0]    h_vld;
  logic [DEPTH-1:0]    h_pnd;
  logic [RS_WIDTH-1:0] h_rd  [DEPTH];
  logic [XLEN-1:0]     h_val [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_vld <= '0;
      h_pnd <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        h_rd[k]  <= '0;
        h_val[k] <= '0;
      end
    end else if (!i_enable) begin
      h_vld <= '0;
      h_pnd <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        h_rd[k]  <= '0;
        h_val[k] <= '0;
      end
    end else if (i_stall) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (i_resolve_valid && h_pnd[k]) begin
          h_pnd[k] <= 1'b0;
          h_val[k] <= i_resolve_value;
        end
      end
    end else begin
      // New entry never takes the resolve: it targets the older one.
      h_vld[0] <= i_result_valid;
      h_pnd[0] <= i_result_valid & i_result_pending;
      h_rd[0]  <= i_result_rd;
      h_val[0] <= i_result_value;
      // Resolve follows the entry to its shifted slot; from the
      // last slot it falls off together with the entry.
      for (int k = 1; k < DEPTH; k++) begin
        h_vld[k] <= h_vld[k-1];
        h_rd[k]  <= h_rd[k-1];
        if (i_resolve_valid && h_pnd[k-1]) begin
          h_pnd[k] <= 1'b0;
          h_val[k] <= i_resolve_value;
        end else begin
          h_pnd[k] <= h_pnd[k-1];
          h_val[k] <= h_val[k-1];
        end
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [RS_WIDTH-1:0] rs;
    logic [XLEN-1:0]     rf;
    logic [XLEN-1:0]     val;
    logic                fwd;
    logic                haz;
    logic                hit;
    logic                wp;
    logic [XLEN-1:0]     wv;

    assign rs = i_rs[p*RS_WIDTH +: RS_WIDTH];
    assign rf = i_rs_value[p*XLEN +: XLEN];

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
      hit = 1'b0;
      wp  = 1'b0;
      wv  = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (h_vld[k] && (h_rd[k] == rs)) begin
          hit = 1'b1;
          wp  = h_pnd[k];
          wv  = h_val[k];
        end
      end
    end

    always_comb begin
      val = rf;
      fwd = 1'b0;
      haz = 1'b0;
      if (hit && (rs != '0)) begin
        if (!wp) begin
          val = wv;
          fwd = 1'b1;
        end else if (i_resolve_valid) begin
          val = i_resolve_value;
          fwd = 1'b1;
        end else begin
          haz = 1'b1;
        end
      end
    end

    assign o_rs_value[p*XLEN +: XLEN] = val;
    assign o_forwarded[p] = fwd;
    assign o_hazard[p]    = haz;
  end

endmodule

// File: tb/tb_rice_core_ex_forwarding_unit.sv
// Bench for rice_core_ex_forwarding_unit: two configurations
// (2x2 and 4x3) against a queue-based reference model.
module tb_rice_core_ex_forwarding_unit;

  localparam int DA = 2;
  localparam int PA = 2;
  localparam int DB = 4;
  localparam int PB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic stall = 1'b0;
  logic rv = 1'b0;
  logic rpend = 1'b0;
  logic resv = 1'b0;
  logic [4:0]  rrd = '0;
  logic [31:0] rval = '0;
  logic [31:0] resval = '0;

  logic [PA*5-1:0]  rs_a = '0;
  logic [PA*32-1:0] rsv_a = '0;
  logic [PA*32-1:0] out_a;
  logic [PA-1:0]    fw_a, hz_a;

  logic [PB*5-1:0]  rs_b = '0;
  logic [PB*32-1:0] rsv_b = '0;
  logic [PB*32-1:0] out_b;
  logic [PB-1:0]    fw_b, hz_b;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rice_core_ex_forwarding_unit #(
    .XLEN(32), .RS_WIDTH(5), .DEPTH(DA), .READ_PORTS(PA)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_stall(stall),
    .i_result_valid(rv), .i_result_rd(rrd),
    .i_result_value(rval), .i_result_pending(rpend),
    .i_resolve_valid(resv), .i_resolve_value(resval),
    .i_rs(rs_a), .i_rs_value(rsv_a),
    .o_rs_value(out_a), .o_forwarded(fw_a), .o_hazard(hz_a)
  );

  rice_core_ex_forwarding_unit #(
    .XLEN(32), .RS_WIDTH(5), .DEPTH(DB), .READ_PORTS(PB)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_stall(stall),
    .i_result_valid(rv), .i_result_rd(rrd),
    .i_result_value(rval), .i_result_pending(rpend),
    .i_resolve_valid(resv), .i_resolve_value(resval),
    .i_rs(rs_b), .i_rs_value(rsv_b),
    .o_rs_value(out_b), .o_forwarded(fw_b), .o_hazard(hz_b)
  );

  typedef struct packed {
    logic        v;
    logic        p;
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  typedef struct packed {
    logic [31:0] val;
    logic        fw;
    logic        hz;
  } res_t;

  typedef ent_t ent_q_t[$];

  ent_q_t qa, qb;

  function automatic ent_q_t zeros(int d);
    ent_q_t n;
    for (int i = 0; i < d; i++) n.push_back('0);
    return n;
  endfunction

  function automatic ent_q_t nxt(ent_q_t q, int d);
    ent_q_t n;
    ent_t e;
    n = q;
    if (!en) return zeros(d);
    if (resv) begin
      for (int i = 0; i < n.size(); i++) begin
        if (n[i].p) begin
          n[i].p = 1'b0;
          n[i].val = resval;
        end
      end
    end
    if (!stall) begin
      e.v = rv;
      e.p = rv & rpend;
      e.rd = rrd;
      e.val = rval;
      n.push_front(e);
      void'(n.pop_back());
    end
    return n;
  endfunction

  function automatic res_t look(ent_q_t q, logic [4:0] rs,
                                logic [31:0] rf);
    res_t r;
    bit found;
    r.val = rf;
    r.fw = 1'b0;
    r.hz = 1'b0;
    found = 0;
    if (rs != 5'd0) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!found && q[i].v && q[i].rd == rs) begin
          found = 1;
          if (!q[i].p) begin
            r.val = q[i].val;
            r.fw = 1'b1;
          end else if (resv) begin
            r.val = resval;
            r.fw = 1'b1;
          end else begin
            r.hz = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic bit anypend();
    bit a;
    a = 0;
    foreach (qa[i]) if (qa[i].p) a = 1;
    foreach (qb[i]) if (qb[i].p) a = 1;
    return a;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    res_t e;
    for (int p = 0; p < PA; p++) begin
      e = look(qa, rs_a[p*5 +: 5], rsv_a[p*32 +: 32]);
      chk($sformatf("a%0d.val", p), out_a[p*32 +: 32], e.val);
      chk($sformatf("a%0d.fw", p), 32'(fw_a[p]), 32'(e.fw));
      chk($sformatf("a%0d.hz", p), 32'(hz_a[p]), 32'(e.hz));
    end
    for (int p = 0; p < PB; p++) begin
      e = look(qb, rs_b[p*5 +: 5], rsv_b[p*32 +: 32]);
      chk($sformatf("b%0d.val", p), out_b[p*32 +: 32], e.val);
      chk($sformatf("b%0d.fw", p), 32'(fw_b[p]), 32'(e.fw));
      chk($sformatf("b%0d.hz", p), 32'(hz_b[p]), 32'(e.hz));
    end
  endtask

  task automatic step();
    #1 cmp_all();
    @(posedge clk);
    if (rst) begin
      qa = zeros(DA);
      qb = zeros(DB);
    end else begin
      qa = nxt(qa, DA);
      qb = nxt(qb, DB);
    end
    @(negedge clk);
  endtask

  task automatic push(logic v, logic [4:0] rd,
                      logic [31:0] val, logic p);
    rv = v;
    rrd = rd;
    rval = val;
    rpend = p;
  endtask

  task automatic setrs(int p, logic [4:0] rs, logic [31:0] rf);
    if (p < PA) begin
      rs_a[p*5 +: 5] = rs;
      rsv_a[p*32 +: 32] = rf;
    end
    rs_b[p*5 +: 5] = rs;
    rsv_b[p*32 +: 32] = rf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    qa = zeros(DA);
    qb = zeros(DB);
    @(negedge clk);
    for (int p = 0; p < PB; p++) setrs(p, 5'd5, 32'h100 + p);
    #1 chk("rst_fw", 32'(fw_a), 32'd0);
    chk("rst_val", out_a[31:0], 32'h100);
    step();
    rst = 1'b0;
    en = 1'b1;

    push(1, 5, 32'h11, 0); step();
    push(1, 5, 32'h22, 0); step();
    push(0, 0, 0, 0);
    #1 chk("young_a", out_a[31:0], 32'h22);
    chk("young_fw", 32'(fw_a[0]), 32'd1);
    chk("young_b", out_b[31:0], 32'h22);
    step();
    repeat (DB) step();
    #1 chk("aged_fw_a", 32'(fw_a), 32'd0);
    chk("aged_val_a", out_a[31:0], 32'h100);
    chk("aged_fw_b", 32'(fw_b), 32'd0);

    push(1, 0, 32'hDEAD, 0);
    for (int p = 0; p < PB; p++) setrs(p, 5'd0, 32'd0);
    step();
    push(0, 0, 0, 0);
    #1 chk("rs0_val", out_a[31:0], 32'd0);
    chk("rs0_fw", 32'(fw_a[0]), 32'd0);
    step();

    push(1, 7, 32'h777, 1);
    for (int p = 0; p < PB; p++) setrs(p, 5'd7, 32'h70 + p);
    step();
    push(0, 0, 0, 0);
    stall = 1'b1;
    #1 chk("pend_hz_a", 32'(hz_a[0]), 32'd1);
    chk("pend_hz_b", 32'(hz_b[2]), 32'd1);
    chk("pend_val", out_a[31:0], 32'h70);
    step();
    resv = 1'b1;
    resval = 32'hCAFE;
    #1 chk("byp_val", out_a[31:0], 32'hCAFE);
    chk("byp_hz", 32'(hz_a[0]), 32'd0);
    chk("byp_fw", 32'(fw_a[0]), 32'd1);
    step();
    resv = 1'b0;
    stall = 1'b0;
    #1 chk("hist_val", out_a[31:0], 32'hCAFE);
    chk("hist_fw", 32'(fw_a[0]), 32'd1);
    step();

    push(1, 8, 32'h888, 1);
    setrs(0, 5'd8, 32'h80);
    setrs(1, 5'd9, 32'h90);
    setrs(2, 5'd8, 32'h82);
    step();
    push(1, 9, 32'h99, 0);
    resv = 1'b1;
    resval = 32'hBEEF;
    #1 chk("sh_byp", out_a[31:0], 32'hBEEF);
    chk("sh_nobyp", out_a[63:32], 32'h90);
    step();
    push(0, 0, 0, 0);
    resv = 1'b0;
    stall = 1'b1;
    repeat (3) begin
      #1 chk("stl_rd8", out_a[31:0], 32'hBEEF);
      chk("stl_rd9", out_a[63:32], 32'h99);
      chk("stl_hz", 32'(hz_a), 32'd0);
      step();
    end
    stall = 1'b0;

    push(1, 10, 32'hA0, 1);
    setrs(0, 5'd10, 32'h1);
    setrs(1, 5'd11, 32'h2);
    setrs(2, 5'd10, 32'h3);
    step();
    push(1, 11, 32'hB0, 1);
    resv = 1'b1;
    resval = 32'h1234;
    #1 chk("dp_old", out_a[31:0], 32'h1234);
    step();
    push(0, 0, 0, 0);
    resv = 1'b0;
    stall = 1'b1;
    #1 chk("dp_res", out_a[31:0], 32'h1234);
    chk("dp_hz", 32'(hz_a[1]), 32'd1);
    step();
    resv = 1'b1;
    resval = 32'h5678;
    #1 chk("dp_new", out_a[63:32], 32'h5678);
    step();
    resv = 1'b0;
    stall = 1'b0;

    push(1, 12, 32'hC0, 1);
    setrs(0, 5'd12, 32'h5);
    step();
    push(0, 0, 0, 0);
    stall = 1'b1;
    #1 chk("pre_rst_hz", 32'(hz_a[0]), 32'd1);
    #1 rst = 1'b1;
    qa = zeros(DA);
    qb = zeros(DB);
    #1 chk("arst_hz", 32'(hz_a[0]), 32'd0);
    chk("arst_val", out_a[31:0], 32'h5);
    step();
    rst = 1'b0;
    stall = 1'b0;

    push(1, 13, 32'hD0, 0);
    setrs(0, 5'd13, 32'h6);
    step();
    push(0, 0, 0, 0);
    #1 chk("pre_en", out_a[31:0], 32'hD0);
    en = 1'b0;
    step();
    en = 1'b1;
    #1 chk("en_clr_fw", 32'(fw_a[0]), 32'd0);
    chk("en_clr_val", out_a[31:0], 32'h6);
    step();

    push(1, 9, 32'hB, 0); step();
    push(1, 3, 32'hA, 0); step();
    push(0, 0, 0, 0); step(); step();
    setrs(0, 5'd3, 32'h30);
    setrs(1, 5'd3, 32'h31);
    setrs(2, 5'd9, 32'h32);
    #1 chk("d4_p0", out_b[31:0], 32'hA);
    chk("d4_p1", out_b[63:32], 32'hA);
    chk("d4_p2", out_b[95:64], 32'hB);
    chk("d4_fw", 32'(fw_b), 32'd7);
    step();

    repeat (400) begin
      en = ($urandom_range(0, 19) != 0);
      stall = ($urandom_range(0, 4) == 0);
      push($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
           $urandom, !anypend() && ($urandom_range(0, 4) == 0));
      resv = ($urandom_range(0, 9) < 3);
      resval = $urandom;
      for (int p = 0; p < PB; p++)
        setrs(p, 5'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
